// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Purpose  : MEM-stage load/store controller driving a valid/ready data bus
// Revision : 1.0
// ============================================================================

package dmem_access_pkg;
   typedef enum logic [2:0] {
      MEM_NO = 3'd0,
      MEM_B  = 3'd1,
      MEM_H  = 3'd2,
      MEM_W  = 3'd3,
      MEM_D  = 3'd4,
      MEM_UB = 3'd5,
      MEM_UH = 3'd6,
      MEM_UW = 3'd7
   } mem_op_enum;
endpackage

module dmem_access_ctrl
   import dmem_access_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  mem_op_enum  req_op,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [63:0] req_wmask,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_addr,
   output logic        mem_wen,
   output logic [63:0] mem_wdata,
   output logic [63:0] mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_rdata,
   output logic        rsp_valid,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err,
   output logic        stall
);

   localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mem_op_enum       op_q, op_d;
   logic             we_q, we_d;
   logic [2:0]       off_q, off_d;
   logic             mem_req_valid_q, mem_req_valid_d;
   logic [63:0]      mem_addr_q, mem_addr_d;
   logic             mem_wen_q, mem_wen_d;
   logic [63:0]      mem_wdata_q, mem_wdata_d;
   logic [63:0]      mem_wmask_q, mem_wmask_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [63:0]      rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;

   // Natural alignment; byte accesses can never be misaligned.
   function automatic logic is_misaligned(input mem_op_enum op, input logic [2:0] a);
      case (op)
         MEM_H, MEM_UH: return a[0];
         MEM_W, MEM_UW: return |a[1:0];
         MEM_D:         return |a[2:0];
         default:       return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] load_extend(input mem_op_enum op,
                                               input logic [2:0] a,
                                               input logic [63:0] raw);
      logic [63:0] d;
      d = raw >> {a, 3'b000};
      case (op)
         MEM_B:   return {{56{d[7]}}, d[7:0]};
         MEM_UB:  return {56'd0, d[7:0]};
         MEM_H:   return {{48{d[15]}}, d[15:0]};
         MEM_UH:  return {48'd0, d[15:0]};
         MEM_W:   return {{32{d[31]}}, d[31:0]};
         MEM_UW:  return {32'd0, d[31:0]};
         MEM_D:   return d;
         default: return 64'd0;
      endcase
   endfunction

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      op_d            = op_q;
      we_d            = we_q;
      off_d           = off_q;
      mem_req_valid_d = mem_req_valid_q;
      mem_addr_d      = mem_addr_q;
      mem_wen_d       = mem_wen_q;
      mem_wdata_d     = mem_wdata_q;
      mem_wmask_d     = mem_wmask_q;
      rsp_valid_d     = 1'b0;
      rsp_rdata_d     = 64'd0;
      rsp_err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d        = req_op;
               we_d        = req_we;
               off_d       = req_addr[2:0];
               mem_addr_d  = {req_addr[63:3], 3'b000};
               mem_wen_d   = req_we;
               mem_wdata_d = req_wdata << {req_addr[2:0], 3'b000};
               mem_wmask_d = req_we ? req_wmask : 64'd0;
               if (req_op == MEM_NO) begin
                  state_d     = ST_DONE;
                  rsp_valid_d = 1'b1;
               end else if (is_misaligned(req_op, req_addr[2:0])) begin
                  state_d     = ST_DONE;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d         = ST_REQ;
                  mem_req_valid_d = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               state_d         = ST_WAIT;
               mem_req_valid_d = 1'b0;
               cnt_d           = '0;
            end
         end
         ST_WAIT: begin
            // A response in the timeout cycle takes priority over the error.
            if (mem_resp_valid) begin
               state_d     = ST_DONE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = we_q ? 64'd0 : load_extend(op_q, off_q, mem_rdata);
            end else if (cnt_q == CNT_LAST) begin
               state_d     = ST_DONE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         op_q            <= MEM_NO;
         we_q            <= 1'b0;
         off_q           <= 3'd0;
         mem_req_valid_q <= 1'b0;
         mem_addr_q      <= 64'd0;
         mem_wen_q       <= 1'b0;
         mem_wdata_q     <= 64'd0;
         mem_wmask_q     <= 64'd0;
         rsp_valid_q     <= 1'b0;
         rsp_rdata_q     <= 64'd0;
         rsp_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         op_q            <= op_d;
         we_q            <= we_d;
         off_q           <= off_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_addr_q      <= mem_addr_d;
         mem_wen_q       <= mem_wen_d;
         mem_wdata_q     <= mem_wdata_d;
         mem_wmask_q     <= mem_wmask_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_rdata_q     <= rsp_rdata_d;
         rsp_err_q       <= rsp_err_d;
      end
   end

   assign req_ready     = (state_q == ST_IDLE);
   assign mem_req_valid = mem_req_valid_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wen       = mem_wen_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wmask     = mem_wmask_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;

   // Low in DONE so the MEM stage advances on the completing edge.
   assign stall = ((state_q == ST_IDLE) && req_valid && (req_op != MEM_NO)) ||
                  (state_q == ST_REQ) || (state_q == ST_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Purpose  : Randomized scoreboard bench for dmem_access_ctrl
// Revision : 1.0
// ============================================================================

module tb_dmem_access_ctrl;
   import dmem_access_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   mem_op_enum  req_op = MEM_NO;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic [63:0] req_wmask = 64'd0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [63:0] mem_addr;
   logic        mem_wen;
   logic [63:0] mem_wdata;
   logic [63:0] mem_wmask;
   logic        mem_resp_valid = 1'b0;
   logic [63:0] mem_rdata = 64'd0;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic        stall;

   dmem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] addr, wdata, wmask, rdata;
      logic        wen;
      int          r, d;
   } bus_t;

   typedef struct {
      logic [63:0] data;
      logic        err;
      int          cyc;
   } rsp_t;

   bus_t bus_q[$];
   rsp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   bus_auto = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int op_size(input mem_op_enum op);
      case (op)
         MEM_B, MEM_UB: return 1;
         MEM_H, MEM_UH: return 2;
         MEM_W, MEM_UW: return 4;
         MEM_D:         return 8;
         default:       return 0;
      endcase
   endfunction

   function automatic bit op_signed(input mem_op_enum op);
      return (op == MEM_B) || (op == MEM_H) || (op == MEM_W) || (op == MEM_D);
   endfunction

   function automatic logic [63:0] ref_load(input mem_op_enum op, input int off,
                                            input logic [63:0] raw);
      logic [63:0] v, m;
      int          sz;
      sz = op_size(op);
      v  = raw >> (8 * off);
      if (sz == 8) return v;
      m = (64'd1 << (8 * sz)) - 64'd1;
      v = v & m;
      if (op_signed(op) && v[8*sz-1]) v = v | ~m;
      return v;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle();
      int n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("idle_wait_expired", 64'd0, 64'd1);
   endtask

   task automatic issue(input logic we, input mem_op_enum op, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] wmask,
                        input logic [63:0] rdata, input int r, input int d);
      int   off, sz, a;
      bit   mis;
      bus_t b;
      rsp_t e;
      wait_idle();
      off = int'(addr[2:0]);
      sz  = op_size(op);
      mis = (op != MEM_NO) && ((off % sz) != 0);
      req_valid = 1'b1;
      req_we    = we;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      req_wmask = wmask;
      a = cyc + 1;
      #1;
      chk("stall_on_request", {63'd0, stall}, {63'd0, op != MEM_NO});
      e.data = 64'd0;
      e.err  = 1'b0;
      if (op == MEM_NO) begin
         e.cyc = a;
      end else if (mis) begin
         e.err = 1'b1;
         e.cyc = a;
      end else begin
         b.addr  = addr & ~64'd7;
         b.wen   = we;
         b.wdata = wdata << (8 * off);
         b.wmask = we ? wmask : 64'd0;
         b.rdata = rdata;
         b.r     = r;
         b.d     = d;
         bus_q.push_back(b);
         if (d < TO) begin
            e.data = we ? 64'd0 : ref_load(op, off, rdata);
            e.cyc  = a + r + 2 + d;
         end else begin
            e.err = 1'b1;
            e.cyc = a + r + 1 + TO;
         end
      end
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      req_wmask = {$urandom, $urandom};
   endtask

   // ---------------- bus model ----------------
   initial begin : bus_model
      bus_t b;
      forever begin
         @(negedge clk);
         if (bus_auto && rstn && mem_req_valid) begin
            if (bus_q.size() == 0) begin
               chk("bus_unexpected_request", 64'd1, 64'd0);
               mem_req_ready = 1'b1;
               @(negedge clk);
               mem_req_ready = 1'b0;
            end else begin
               b = bus_q.pop_front();
               for (int i = 0; i <= b.r; i++) begin
                  chk("bus_req_valid", {63'd0, mem_req_valid}, 64'd1);
                  chk("bus_addr", mem_addr, b.addr);
                  chk("bus_wen", {63'd0, mem_wen}, {63'd0, b.wen});
                  chk("bus_wdata", mem_wdata, b.wdata);
                  chk("bus_wmask", mem_wmask, b.wmask);
                  chk("bus_stall", {63'd0, stall}, 64'd1);
                  if (i < b.r) @(negedge clk);
               end
               mem_req_ready = 1'b1;
               @(negedge clk);
               mem_req_ready = 1'b0;
               if (b.d < TO) begin
                  repeat (b.d) @(negedge clk);
                  mem_resp_valid = 1'b1;
                  mem_rdata      = b.rdata;
                  @(negedge clk);
                  mem_resp_valid = 1'b0;
                  mem_rdata      = {$urandom, $urandom};
               end
            end
         end
      end
   end

   // ---------------- response monitor ----------------
   always @(negedge clk) begin : monitor
      rsp_t e;
      if (rstn && rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.data);
            chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
            chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            chk("rsp_stall_low", {63'd0, stall}, 64'd0);
            chk("rsp_req_ready_low", {63'd0, req_ready}, 64'd0);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      mem_op_enum op;
      logic       we;
      logic [63:0] addr, m;
      int          off, sz;

      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
      chk("reset_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
      chk("reset_mem_addr", mem_addr, 64'd0);
      chk("reset_mem_wen", {63'd0, mem_wen}, 64'd0);
      chk("reset_mem_wdata", mem_wdata, 64'd0);
      chk("reset_mem_wmask", mem_wmask, 64'd0);
      chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("reset_rsp_rdata", rsp_rdata, 64'd0);
      chk("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
      chk("reset_stall", {63'd0, stall}, 64'd0);

      // Byte loads with sign and zero extension
      issue(1'b0, MEM_B,  64'h1003, 64'd0, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
      issue(1'b0, MEM_UB, 64'h1003, 64'd0, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
      // Halfword store into the top lane
      issue(1'b1, MEM_H, 64'h2006, 64'hBEEF, 64'hFFFF << 48, 64'h1234, 0, 1);
      // Misaligned word: no bus traffic, error one cycle after accept
      issue(1'b0, MEM_W, 64'h3002, 64'd0, 64'd0, 64'd0, 0, 0);
      // Slow ready then silent bus, response on the last allowed cycle, and one past it
      issue(1'b0, MEM_D, 64'h4000, 64'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 5, 99);
      issue(1'b0, MEM_W, 64'h4004, 64'd0, 64'd0, 64'h8765_4321_0000_0000, 1, TO - 1);
      issue(1'b0, MEM_UW, 64'h4004, 64'd0, 64'd0, 64'h8765_4321_0000_0000, 0, TO);

      // Reset while waiting for a response; the late response must vanish
      wait_idle();
      bus_auto  = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_op    = MEM_D;
      req_addr  = 64'h5000;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_test_req_valid", {63'd0, mem_req_valid}, 64'd1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("rst_test_stall_wait", {63'd0, stall}, 64'd1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("rst_test_req_valid_drop", {63'd0, mem_req_valid}, 64'd0);
      chk("rst_test_req_ready", {63'd0, req_ready}, 64'd1);
      repeat (2) @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_rdata      = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk("rst_test_no_rsp", {63'd0, rsp_valid}, 64'd0);
      chk("rst_test_idle", {63'd0, req_ready}, 64'd1);
      repeat (3) @(negedge clk);
      chk("rst_test_still_idle", {63'd0, req_ready}, 64'd1);
      bus_auto = 1'b1;

      // Back-to-back MEM_NO with req_valid held high
      wait_idle();
      req_valid = 1'b1;
      req_op    = MEM_NO;
      req_we    = 1'b0;
      for (int k = 0; k < 4; k++) exp_q.push_back('{data: 64'd0, err: 1'b0, cyc: cyc + 1 + 2 * k});
      repeat (7) begin
         @(negedge clk);
         chk("memno_stall", {63'd0, stall}, 64'd0);
      end
      req_valid = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         op   = mem_op_enum'($urandom_range(0, 7));
         we   = (op == MEM_B || op == MEM_H || op == MEM_W || op == MEM_D || op == MEM_NO)
                ? 1'($urandom_range(0, 1)) : 1'b0;
         sz   = (op_size(op) == 0) ? 1 : op_size(op);
         off  = $urandom_range(0, 7);
         if ($urandom_range(0, 3) != 0 || op == MEM_UH) off = off - (off % sz);
         addr = {$urandom, $urandom};
         addr = (addr & ~64'd7) | 64'(off);
         m    = (sz == 8) ? ~64'd0 : ((64'd1 << (8 * sz)) - 64'd1) << (8 * off);
         issue(we, op, addr, {$urandom, $urandom}, we ? m : {$urandom, $urandom},
               {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 5));
      end

      wait_idle();
      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
